// File: rtl/alu_pkg.sv
// Shared ALU control encodings: ALUCtl codes, ALUOp values, funct7 groups,
// control FSM states and iterative-datapath operation selector.
package alu_pkg;

    localparam logic [3:0] CTL_ADD  = 4'b0000;
    localparam logic [3:0] CTL_SUB  = 4'b0001;
    localparam logic [3:0] CTL_SLT  = 4'b0010;
    localparam logic [3:0] CTL_OR   = 4'b0011;
    localparam logic [3:0] CTL_AND  = 4'b0100;
    localparam logic [3:0] CTL_XOR  = 4'b0101;
    localparam logic [3:0] CTL_SLL  = 4'b0110;
    localparam logic [3:0] CTL_SRL  = 4'b0111;
    localparam logic [3:0] CTL_SRA  = 4'b1000;
    localparam logic [3:0] CTL_SLTU = 4'b1001;
    localparam logic [3:0] CTL_MUL  = 4'b1010;
    localparam logic [3:0] CTL_DIV  = 4'b1011;
    localparam logic [3:0] CTL_DIVU = 4'b1100;
    localparam logic [3:0] CTL_REM  = 4'b1101;
    localparam logic [3:0] CTL_REMU = 4'b1110;
    localparam logic [3:0] CTL_CTZ  = 4'b1111;

    localparam logic [1:0] ALUOP_LDST  = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_CTZ   = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_CTZ,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        IT_MUL,
        IT_DIV,
        IT_CTZ
    } iter_op_t;

    // Codes MUL..CTZ are the ones sequenced over several cycles.
    function automatic logic is_multicycle(input logic [3:0] ctl);
        return ctl >= CTL_MUL;
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative shift/accumulate datapath: shift-add multiply, restoring divide
// on magnitudes with sign fixup folded into the final step, and chunked CTZ.
// `done` and `result` are combinational and meaningful while `step` is high.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int CTZ_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  iter_op_t        op,
    input  logic            sgn,
    input  logic            want_rem,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW    = $clog2(XLEN);
    localparam int SCANS = XLEN / CTZ_STEP;

    iter_op_t            op_r;
    logic                rem_r, neg_q, neg_r;
    logic [XLEN-1:0]     acc, opa, opb;
    logic [XLEN-1:0]     acc_n, opa_n, opb_n;
    logic [CW-1:0]       cnt;
    logic [XLEN:0]       trial;
    logic [CTZ_STEP-1:0] chunk;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic s);
        return (s && v[XLEN-1]) ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Index of the lowest set bit in a nonzero chunk.
    function automatic logic [XLEN-1:0] chunk_tz(input logic [CTZ_STEP-1:0] c);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = CTZ_STEP - 1; i >= 0; i--) begin
            if (c[i]) r = XLEN'(i);
        end
        return r;
    endfunction

    // One iteration of the selected algorithm, plus completion and final result.
    always_comb begin
        acc_n  = acc;
        opa_n  = opa;
        opb_n  = opb;
        done   = 1'b0;
        result = acc;
        trial  = {acc, opa[XLEN-1]} - {1'b0, opb};
        chunk  = opa[CTZ_STEP-1:0];
        case (op_r)
            IT_MUL: begin
                if (opb[0]) acc_n = acc + opa;
                opa_n  = opa << 1;
                opb_n  = opb >> 1;
                done   = step && (cnt == CW'(XLEN - 1));
                result = acc_n;
            end
            IT_DIV: begin
                // acc holds the partial remainder, opa shifts dividend out and quotient in
                if (!trial[XLEN]) begin
                    acc_n = trial[XLEN-1:0];
                    opa_n = {opa[XLEN-2:0], 1'b1};
                end else begin
                    acc_n = {acc[XLEN-2:0], opa[XLEN-1]};
                    opa_n = {opa[XLEN-2:0], 1'b0};
                end
                done   = step && (cnt == CW'(XLEN - 1));
                result = rem_r ? apply_sign(acc_n, neg_r) : apply_sign(opa_n, neg_q);
            end
            default: begin
                if (chunk != '0) begin
                    done   = step;
                    result = acc + chunk_tz(chunk);
                end else begin
                    acc_n  = acc + XLEN'(CTZ_STEP);
                    opa_n  = opa >> CTZ_STEP;
                    done   = step && (cnt == CW'(SCANS - 1));
                    result = acc_n;
                end
            end
        endcase
    end

    // Operand capture at start, then advance one iteration per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r  <= IT_MUL;
            rem_r <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
            cnt   <= '0;
        end else if (load) begin
            op_r  <= op;
            rem_r <= want_rem;
            neg_q <= sgn && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r <= sgn && a[XLEN-1];
            acc   <= '0;
            cnt   <= '0;
            opa   <= (op == IT_DIV) ? magnitude(a, sgn) : a;
            opb   <= (op == IT_DIV) ? magnitude(b, sgn) : ((op == IT_MUL) ? b : '0);
        end else if (step) begin
            acc <= acc_n;
            opa <= opa_n;
            opb <= opb_n;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_ctrl_mc.sv
// ALU control: combinational ALUOp/funct decode to ALUCtl, plus the FSM that
// sequences MUL/DIV/CTZ through alu_iter_core, drives stall and handles the
// divide corner cases without iterating.
module alu_ctrl_mc
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1,
    parameter int CTZ_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      ALUCtl,
    output logic            illegal,
    output logic            stall,
    output logic            mc_valid,
    output logic [XLEN-1:0] mc_result
);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_n;
    logic            start, step, fast, core_done;
    logic            is_div, is_sdiv, div_zero, div_ovf;
    logic [XLEN-1:0] fast_res, core_res;
    iter_op_t        it_op;

    // Instruction decode to ALU operation code.
    always_comb begin
        ALUCtl  = CTL_ADD;
        illegal = 1'b0;
        case (ALUOp)
            ALUOP_LDST: ALUCtl = CTL_ADD;
            ALUOP_BR:   ALUCtl = CTL_SUB;
            ALUOP_CTZ:  ALUCtl = CTL_CTZ;
            ALUOP_RTYPE: begin
                illegal = 1'b1;
                if (funct7 == F7_BASE) begin
                    illegal = 1'b0;
                    case (funct3)
                        3'b000:  ALUCtl = CTL_ADD;
                        3'b001:  ALUCtl = CTL_SLL;
                        3'b010:  ALUCtl = CTL_SLT;
                        3'b011:  ALUCtl = CTL_SLTU;
                        3'b100:  ALUCtl = CTL_XOR;
                        3'b101:  ALUCtl = CTL_SRL;
                        3'b110:  ALUCtl = CTL_OR;
                        default: ALUCtl = CTL_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    ALUCtl  = CTL_SUB;
                    illegal = 1'b0;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    ALUCtl  = CTL_SRA;
                    illegal = 1'b0;
                end else if (ENABLE_M != 0 && funct7 == F7_MEXT) begin
                    case (funct3)
                        3'b000:  begin ALUCtl = CTL_MUL;  illegal = 1'b0; end
                        3'b100:  begin ALUCtl = CTL_DIV;  illegal = 1'b0; end
                        3'b101:  begin ALUCtl = CTL_DIVU; illegal = 1'b0; end
                        3'b110:  begin ALUCtl = CTL_REM;  illegal = 1'b0; end
                        3'b111:  begin ALUCtl = CTL_REMU; illegal = 1'b0; end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Divide corner detection and their immediate results.
    always_comb begin
        is_div   = ALUCtl inside {CTL_DIV, CTL_DIVU, CTL_REM, CTL_REMU};
        is_sdiv  = (ALUCtl == CTL_DIV) || (ALUCtl == CTL_REM);
        div_zero = (op_b == '0);
        div_ovf  = is_sdiv && (op_a == INT_MIN) && (op_b == '1);
        fast     = is_div && (div_zero || div_ovf);
        if (div_zero)
            fast_res = (ALUCtl == CTL_DIV || ALUCtl == CTL_DIVU) ? '1 : op_a;
        else
            fast_res = (ALUCtl == CTL_DIV) ? INT_MIN : '0;
        if (ALUCtl == CTL_MUL)      it_op = IT_MUL;
        else if (ALUCtl == CTL_CTZ) it_op = IT_CTZ;
        else                        it_op = IT_DIV;
    end

    // Next state, stall and result strobe.
    always_comb begin
        state_n  = state;
        start    = 1'b0;
        step     = 1'b0;
        stall    = 1'b0;
        mc_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_i && !flush_i && !illegal && is_multicycle(ALUCtl)) begin
                    start = 1'b1;
                    stall = 1'b1;
                    if (fast)                 state_n = ST_DONE;
                    else if (it_op == IT_MUL) state_n = ST_MUL;
                    else if (it_op == IT_CTZ) state_n = ST_CTZ;
                    else                      state_n = ST_DIV;
                end
            end
            ST_MUL, ST_DIV, ST_CTZ: begin
                stall = 1'b1;
                if (flush_i) begin
                    state_n = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (core_done) state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                mc_valid = 1'b1;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Result register: loaded on entry to DONE, otherwise held.
    always_ff @(posedge clk) begin
        if (rst)                    mc_result <= '0;
        else if (start && fast)     mc_result <= fast_res;
        else if (step && core_done) mc_result <= core_res;
    end

    alu_iter_core #(
        .XLEN     (XLEN),
        .CTZ_STEP (CTZ_STEP)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .step     (step),
        .op       (it_op),
        .sgn      (is_sdiv),
        .want_rem ((ALUCtl == CTL_REM) || (ALUCtl == CTL_REMU)),
        .a        (op_a),
        .b        (op_b),
        .done     (core_done),
        .result   (core_res)
    );

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Directed bench for alu_ctrl_mc: decode sweep on M-enabled and M-disabled
// instances, multi-cycle ops checked through an expected-result queue.
module tb_alu_ctrl_mc;
    localparam logic [6:0] F7B = 7'h00;
    localparam logic [6:0] F7A = 7'h20;
    localparam logic [6:0] F7M = 7'h01;

    logic        clk = 1'b0;
    logic        rst, valid_i, flush_i;
    logic [1:0]  ALUOp;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [3:0]  ctl1, ctl0;
    logic        ill1, ill0, stall, stall0, mc_valid, mc_valid0;
    logic [31:0] mc_result, mc_result0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alu_ctrl_mc #(.XLEN(32), .ENABLE_M(1), .CTZ_STEP(4)) u_dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp(ALUOp), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .ALUCtl(ctl1), .illegal(ill1), .stall(stall), .mc_valid(mc_valid),
        .mc_result(mc_result)
    );

    alu_ctrl_mc #(.XLEN(32), .ENABLE_M(0), .CTZ_STEP(4)) u_nom (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp(ALUOp), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .ALUCtl(ctl0), .illegal(ill0), .stall(stall0), .mc_valid(mc_valid0),
        .mc_result(mc_result0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void exp_dec(input logic [6:0] f7, input logic [2:0] f3, input bit m,
                                    output logic [3:0] ctl, output logic ill);
        logic [3:0] base_t [8];
        base_t = '{4'd0, 4'd6, 4'd2, 4'd9, 4'd5, 4'd7, 4'd3, 4'd4};
        ctl = 4'd0;
        ill = 1'b1;
        if (f7 == 7'h00) begin
            ctl = base_t[f3]; ill = 1'b0;
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
            ctl = 4'd1; ill = 1'b0;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
            ctl = 4'd8; ill = 1'b0;
        end else if (f7 == 7'h01 && m) begin
            case (f3)
                3'd0: begin ctl = 4'd10; ill = 1'b0; end
                3'd4: begin ctl = 4'd11; ill = 1'b0; end
                3'd5: begin ctl = 4'd12; ill = 1'b0; end
                3'd6: begin ctl = 4'd13; ill = 1'b0; end
                3'd7: begin ctl = 4'd14; ill = 1'b0; end
                default: ;
            endcase
        end
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns #1 after the
    // cycle following the result strobe.
    task automatic run_op(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int n;
        int ns;
        logic [31:0] e;
        ALUOp = aop; funct7 = f7; funct3 = f3; op_a = a; op_b = b; valid_i = 1'b1;
        #1;
        chk({tag, "_start_stall"}, 32'(stall), 32'd1);
        if (aop == 2'b10 && f7 == F7M) chk({tag, "_nom_no_start"}, 32'(stall0), 32'd0);
        exp_q.push_back(exp);
        tick();
        valid_i = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        n  = 1;
        ns = 1;
        while (!mc_valid && n < 100) begin
            if (stall) ns++;
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_stall_cycles"}, 32'(ns), 32'(lat));
        if (mc_valid) begin
            chk({tag, "_done_stall"}, 32'(stall), 32'd0);
            if (exp_q.size() == 0) begin
                chk({tag, "_queue_empty"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_result"}, mc_result, e);
            end
            if (aop == 2'b11) begin
                chk({tag, "_nom_valid"}, 32'(mc_valid0), 32'd1);
                chk({tag, "_nom_result"}, mc_result0, exp);
            end
        end else begin
            void'(exp_q.pop_front());
        end
        tick();
        chk({tag, "_valid_one_cycle"}, 32'(mc_valid), 32'd0);
        chk({tag, "_result_held"}, mc_result, exp);
    endtask

    initial begin
        logic [3:0] ec;
        logic       ei;
        logic [6:0] f7;
        bit         seen;

        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        ALUOp = 2'b00; funct7 = 7'h00; funct3 = 3'd0; op_a = '0; op_b = '0;
        tick();
        tick();
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_mc_valid", 32'(mc_valid), 32'd0);
        chk("reset_mc_result", mc_result, 32'd0);
        rst = 1'b0;

        // decode sweep
        for (int s = 0; s < 3; s++) begin
            for (int f = 0; f < 8; f++) begin
                f7 = (s == 0) ? F7B : ((s == 1) ? F7A : F7M);
                ALUOp = 2'b10; funct7 = f7; funct3 = 3'(f);
                #1;
                exp_dec(f7, 3'(f), 1'b1, ec, ei);
                chk($sformatf("dec_m1_ctl f7=%h f3=%0d", f7, f), 32'(ctl1), 32'(ec));
                chk($sformatf("dec_m1_ill f7=%h f3=%0d", f7, f), 32'(ill1), 32'(ei));
                exp_dec(f7, 3'(f), 1'b0, ec, ei);
                chk($sformatf("dec_m0_ctl f7=%h f3=%0d", f7, f), 32'(ctl0), 32'(ec));
                chk($sformatf("dec_m0_ill f7=%h f3=%0d", f7, f), 32'(ill0), 32'(ei));
            end
        end
        ALUOp = 2'b10; funct7 = 7'h7F; funct3 = 3'd0; #1;
        chk("dec_bad_f7_ill", 32'(ill1), 32'd1);
        chk("dec_bad_f7_ctl", 32'(ctl1), 32'd0);
        ALUOp = 2'b00; funct7 = 7'h55; funct3 = 3'd3; #1;
        chk("dec_ldst", 32'({ill1, ctl1}), 32'h00);
        ALUOp = 2'b01; #1;
        chk("dec_branch", 32'({ill1, ctl1}), 32'h01);
        ALUOp = 2'b11; #1;
        chk("dec_ctz", 32'({ill1, ctl1}), 32'h0F);
        ALUOp = 2'b00;
        tick();

        // multi-cycle ops, several back-to-back
        run_op("mul_7_m3",   2'b10, F7M, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("div_m7_2",   2'b10, F7M, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_op("rem_m7_2",   2'b10, F7M, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_op("div_7_m2",   2'b10, F7M, 3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op("rem_7_m2",   2'b10, F7M, 3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
        run_op("divu_100_7", 2'b10, F7M, 3'd5, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", 2'b10, F7M, 3'd7, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu_7_0",   2'b10, F7M, 3'd5, 32'd7, 32'd0, 32'hFFFFFFFF, 1);
        run_op("remu_7_0",   2'b10, F7M, 3'd7, 32'd7, 32'd0, 32'd7, 1);
        run_op("div_ovf",    2'b10, F7M, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",    2'b10, F7M, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        run_op("ctz_100",    2'b11, 7'h00, 3'd0, 32'h00000100, 32'd0, 32'd8, 4);
        run_op("ctz_0",      2'b11, 7'h00, 3'd0, 32'h00000000, 32'd0, 32'd32, 9);
        run_op("ctz_msb",    2'b11, 7'h00, 3'd0, 32'h80000000, 32'd0, 32'd31, 9);
        run_op("mul_5_6",    2'b10, F7M, 3'd0, 32'd5, 32'd6, 32'd30, 33);

        // flush mid-MUL: no strobe, result keeps 30
        ALUOp = 2'b10; funct7 = F7M; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; valid_i = 1'b1;
        #1;
        chk("flush_start_stall", 32'(stall), 32'd1);
        tick();
        valid_i = 1'b0;
        repeat (5) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_idle_stall", 32'(stall), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            if (mc_valid) seen = 1'b1;
            tick();
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        chk("flush_result_kept", mc_result, 32'd30);

        // flush wins over a simultaneous start
        valid_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("flush_vs_start_stall", 32'(stall), 32'd0);
        tick();
        valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_vs_start_idle", 32'(stall), 32'd0);

        // reset at cycle 10 of a DIV
        ALUOp = 2'b10; funct7 = F7M; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd9; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (9) tick();
        chk("rst_pre_busy", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_valid", 32'(mc_valid), 32'd0);
        chk("rst_mid_result", mc_result, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            if (mc_valid) seen = 1'b1;
            tick();
        end
        chk("rst_no_valid", 32'(seen), 32'd0);

        // back-to-back MUL then DIV after reset
        run_op("b2b_mul", 2'b10, F7M, 3'd0, 32'h12345678, 32'h10, 32'h23456780, 33);
        run_op("b2b_div", 2'b10, F7M, 3'd4, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
